// File: rtl/mips_shift_pkg.sv
// Shared types and helpers for the multi-cycle right shifter.
// Pure declarations: no latency, no flow control.
package mips_shift_pkg;

   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sr_state_t;

   // Shift cycles needed for a given amount; callers pass b > 0.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/shift_right_unit_step.sv
// One shifter slice: acc >> k with the vacated MSBs filled by sign.
// Purely combinational; no state, no flow control.
module sr_step #(
   parameter int WIDTH = 32,
   parameter int KW    = 6
) (
   input  logic [WIDTH-1:0] i_acc,
   input  logic [KW-1:0]    i_k,
   input  logic             i_sign,
   output logic [WIDTH-1:0] o_res
);

   logic [WIDTH-1:0] w_fill;

   // Ones in exactly the k top positions; k == WIDTH yields an all-ones mask.
   assign w_fill = ~({WIDTH{1'b1}} >> i_k);
   assign o_res  = (i_acc >> i_k) | (i_sign ? w_fill : '0);

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle SRL/SRA/SRLV/SRAV unit, STEP bits per cycle; done pulses ceil(shamt/STEP)+1
// cycles after the accepting edge. start is only sampled in IDLE; flush aborts without a done.
module shift_right_unit
   import mips_shift_pkg::*;
#(
   parameter int STEP  = 4,
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               arith,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               flush,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   data_out
);

   localparam int            KW     = SHAMT_W + 1;
   localparam logic [KW-1:0] STEP_K = KW'(STEP);

   sr_state_t          r_state;
   logic [WIDTH-1:0]   r_acc;
   logic [SHAMT_W-1:0] r_rem;
   logic               r_sign;
   logic               r_done;
   logic [WIDTH-1:0]   r_dout;

   sr_state_t          w_state_nxt;
   logic               w_accept;
   logic               w_emit;
   logic [KW-1:0]      w_rem_ext;
   logic [KW-1:0]      w_k;
   logic [SHAMT_W-1:0] w_rem_nxt;
   logic [WIDTH-1:0]   w_step_res;

   // k is clamped to what is left, so remaining can never wrap.
   assign w_rem_ext = {1'b0, r_rem};
   assign w_k       = (w_rem_ext < STEP_K) ? w_rem_ext : STEP_K;
   assign w_rem_nxt = r_rem - w_k[SHAMT_W-1:0];

   sr_step #(
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_step (
      .i_acc  (r_acc),
      .i_k    (w_k),
      .i_sign (r_sign),
      .o_res  (w_step_res)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_emit      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !flush) begin
               w_accept    = 1'b1;
               w_state_nxt = (shamt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (flush) begin
               w_state_nxt = IDLE;
            end else if (w_rem_nxt == '0) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_emit      = !flush;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // done and data_out are loaded on the same edge so the pulse and result are coherent.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_rem   <= '0;
         r_sign  <= 1'b0;
         r_done  <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_emit;
         if (w_emit) begin
            r_dout <= r_acc;
         end
         if (w_accept) begin
            r_acc  <= data_in;
            r_rem  <= shamt;
            r_sign <= arith & data_in[WIDTH-1];
         end else if (r_state == SHIFT && !flush) begin
            r_acc  <= w_step_res;
            r_rem  <= w_rem_nxt;
         end
      end
   end

   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign data_out = r_dout;

endmodule

// File: tb/tb_shift_right_unit.sv
// Bench for shift_right_unit: vector table plus directed corner sequences on STEP=4,
// then random ops on STEP 4/1/32 instances checked through per-instance scoreboards.
module tb_shift_right_unit;
   import mips_shift_pkg::*;

   localparam int NI = 3;

   typedef struct {
      logic        arith;
      logic [31:0] din;
      logic [4:0]  sh;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic        arith = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] din   = '0;
   logic [4:0]  shamt = '0;
   logic [2:0]  en    = 3'b001;

   logic        bsy  [NI];
   logic        dn   [NI];
   logic [31:0] dout [NI];

   exp_t        sbq [NI][$];
   exp_t        mon_e;
   vec_t        tbl [9];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          cnt;
   int          n;
   logic        ra;
   logic [31:0] rd;
   logic [4:0]  rs;

   shift_right_unit #(.STEP(4), .WIDTH(32)) u_s4 (
      .clk(clk), .rst(rst), .start(start & en[0]), .arith(arith), .data_in(din),
      .shamt(shamt), .flush(flush), .busy(bsy[0]), .done(dn[0]), .data_out(dout[0]));
   shift_right_unit #(.STEP(1), .WIDTH(32)) u_s1 (
      .clk(clk), .rst(rst), .start(start & en[1]), .arith(arith), .data_in(din),
      .shamt(shamt), .flush(flush), .busy(bsy[1]), .done(dn[1]), .data_out(dout[1]));
   shift_right_unit #(.STEP(32), .WIDTH(32)) u_s32 (
      .clk(clk), .rst(rst), .start(start & en[2]), .arith(arith), .data_in(din),
      .shamt(shamt), .flush(flush), .busy(bsy[2]), .done(dn[2]), .data_out(dout[2]));

   always #5 clk = ~clk;

   function automatic int step_of(input int i);
      case (i)
         0:       return 4;
         1:       return 1;
         default: return 32;
      endcase
   endfunction

   function automatic logic [31:0] ref_shift(input logic a, input logic [31:0] d, input logic [4:0] s);
      if (a) return $unsigned($signed(d) >>> s);
      return d >> s;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after each rising edge; cyc counts edges seen.
   always @(posedge clk) begin
      #1;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (dn[i] === 1'b1) begin
            if (sbq[i].size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done_u%0d: got done=1 at cycle %0d expected none", i, cyc);
            end else begin
               mon_e = sbq[i].pop_front();
               chk($sformatf("data_u%0d", i), dout[i], mon_e.dat);
               chk($sformatf("done_cycle_u%0d", i), cyc, mon_e.cyc);
            end
         end
      end
   end

   // Called at a negedge; drives start for one cycle and records expected results.
   task automatic issue(input logic a, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] e4, input int l4, input bit push);
      exp_t e;
      arith = a;
      din   = d;
      shamt = s;
      start = 1'b1;
      if (push) begin
         for (int i = 0; i < NI; i++) begin
            if (en[i]) begin
               if (i == 0) begin
                  e.dat = e4;
                  e.cyc = cyc + 1 + l4;
               end else begin
                  e.dat = ref_shift(a, d, s);
                  e.cyc = cyc + 1 + ceil_div(int'(s), step_of(i)) + 1;
               end
               sbq[i].push_back(e);
            end
         end
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int k = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      if ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) begin
         chk("drain_timeout", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
         for (int i = 0; i < NI; i++) sbq[i].delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000, 2};
      tbl[1] = '{1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001, 9};
      tbl[2] = '{1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9};
      tbl[3] = '{1'b0, 32'h1234_5678, 5'd0,  32'h1234_5678, 1};
      tbl[4] = '{1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 9};
      tbl[5] = '{1'b1, 32'hF000_0000, 5'd5,  32'hFF80_0000, 3};
      tbl[6] = '{1'b0, 32'hF000_0000, 5'd5,  32'h0780_0000, 3};
      tbl[7] = '{1'b1, 32'hDEAD_BEEF, 5'd12, 32'hFFFD_EADB, 4};
      tbl[8] = '{1'b0, 32'hDEAD_BEEF, 5'd12, 32'h000D_EADB, 4};

      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_busy_u%0d", i), bsy[i], 0);
         chk($sformatf("rst_done_u%0d", i), dn[i], 0);
         chk($sformatf("rst_dout_u%0d", i), dout[i], 0);
      end
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 9; t++) begin
         issue(tbl[t].arith, tbl[t].din, tbl[t].sh, tbl[t].exp, tbl[t].lat, 1'b1);
         wait_drain(60);
      end

      // busy spans SHIFT and DONE, dropping as done rises
      issue(1'b1, 32'h8000_0000, 5'd4, 32'hF800_0000, 2, 1'b1);
      cnt = 0;
      n   = 0;
      while (dn[0] !== 1'b1 && n < 20) begin
         if (bsy[0] === 1'b1) cnt++;
         @(negedge clk);
         n++;
      end
      chk("busy_cycles", cnt, 2);
      chk("busy_at_done", bsy[0], 0);
      wait_drain(20);

      // shamt=0 then a start in the very cycle done is high
      issue(1'b0, 32'h1234_5678, 5'd0, 32'h1234_5678, 1, 1'b1);
      @(negedge clk);
      chk("b2b_first_done", dn[0], 1);
      issue(1'b0, 32'h1234_5678, 5'd8, 32'h0012_3456, 3, 1'b1);
      wait_drain(20);

      // start while busy must not disturb the in-flight result
      issue(1'b0, 32'hF0F0_F0F0, 5'd16, 32'h0000_F0F0, 5, 1'b1);
      @(negedge clk);
      chk("busy_before_restart", bsy[0], 1);
      din   = 32'hFFFF_FFFF;
      shamt = 5'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drain(20);
      chk("hold_after_done", dout[0], 32'h0000_F0F0);

      // flush in SHIFT
      issue(1'b0, 32'hABCD_1234, 5'd20, 32'h0, 0, 1'b0);
      repeat (2) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_shift_busy", bsy[0], 0);
      chk("flush_shift_done", dn[0], 0);
      chk("flush_shift_dout", dout[0], 32'h0000_F0F0);
      repeat (10) @(negedge clk);
      chk("flush_shift_dout_later", dout[0], 32'h0000_F0F0);

      // flush while in DONE
      issue(1'b0, 32'h1111_1111, 5'd0, 32'h0, 0, 1'b0);
      chk("pre_flush_done_busy", bsy[0], 1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_done_done", dn[0], 0);
      chk("flush_done_dout", dout[0], 32'h0000_F0F0);
      repeat (3) @(negedge clk);

      // flush in IDLE blocks a same-cycle start
      flush = 1'b1;
      issue(1'b0, 32'h2222_2222, 5'd0, 32'h0, 0, 1'b0);
      flush = 1'b0;
      chk("flush_idle_busy", bsy[0], 0);
      repeat (4) @(negedge clk);
      chk("flush_idle_dout", dout[0], 32'h0000_F0F0);

      // reset mid-operation
      issue(1'b1, 32'h8555_5555, 5'd20, 32'h0, 0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", bsy[0], 0);
      chk("midrst_done", dn[0], 0);
      chk("midrst_dout", dout[0], 0);
      repeat (10) @(negedge clk);
      chk("midrst_dout_later", dout[0], 0);

      // random ops across STEP 4, 1 and 32
      en = 3'b111;
      for (int r = 0; r < 1000; r++) begin
         ra = 1'($urandom_range(0, 1));
         rd = $urandom;
         rs = 5'($urandom_range(0, 31));
         issue(ra, rd, rs, ref_shift(ra, rd, rs), ceil_div(int'(rs), 4) + 1, 1'b1);
         wait_drain(80);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
